// File: rtl/seq_divider.sv
// Restoring divider: one quotient bit per clock under a start/done handshake.
// Splits a DW-bit unsigned dividend by a VW-bit unsigned divisor.
module seq_divider #(
    parameter int DW = 10,
    parameter int VW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic          dz,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder
);

    localparam int CW = $clog2(DW + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(DW - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        CALC = 1'b1
    } state_e;

    // One restoring step: returns {quotient_bit, new_partial_remainder}.
    function automatic logic [VW+1:0] restore_step(
        input logic [VW:0]   rem,
        input logic          din,
        input logic [VW-1:0] dvs
    );
        logic [VW:0] shifted;
        shifted = {rem[VW-1:0], din};
        if (shifted >= {1'b0, dvs}) begin
            restore_step = {1'b1, shifted - {1'b0, dvs}};
        end else begin
            restore_step = {1'b0, shifted};
        end
    endfunction

    state_e        state_q, state_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          dz_q, dz_d;
    logic [DW-1:0] quotient_q, quotient_d;
    logic [VW-1:0] remainder_q, remainder_d;
    logic [DW-1:0] dvd_q, dvd_d;
    logic [VW-1:0] dvs_q, dvs_d;
    logic [VW:0]   rem_q, rem_d;
    logic [DW-1:0] qacc_q, qacc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [VW+1:0] step;

    // Next-state and datapath update for the IDLE/CALC handshake.
    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        dz_d        = dz_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dvd_d       = dvd_q;
        dvs_d       = dvs_q;
        rem_d       = rem_q;
        qacc_d      = qacc_q;
        cnt_d       = cnt_q;
        step        = restore_step(rem_q, dvd_q[DW-1], dvs_q);

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (divisor != {VW{1'b0}}) begin
                        dvd_d   = dividend;
                        dvs_d   = divisor;
                        rem_d   = {(VW+1){1'b0}};
                        qacc_d  = {DW{1'b0}};
                        cnt_d   = {CW{1'b0}};
                        busy_d  = 1'b1;
                        state_d = CALC;
                    end else begin
                        // Divide by zero resolves in a single cycle without entering CALC.
                        quotient_d  = {DW{1'b1}};
                        remainder_d = dividend[VW-1:0];
                        dz_d        = 1'b1;
                        done_d      = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                rem_d  = step[VW:0];
                qacc_d = {qacc_q[DW-2:0], step[VW+1]};
                dvd_d  = {dvd_q[DW-2:0], 1'b0};
                cnt_d  = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                if (cnt_q == LAST_CNT) begin
                    quotient_d  = {qacc_q[DW-2:0], step[VW+1]};
                    remainder_d = step[VW-1:0];
                    dz_d        = 1'b0;
                    done_d      = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = IDLE;
                end else begin
                    state_d = CALC;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset aborts any division in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            dz_q        <= 1'b0;
            quotient_q  <= {DW{1'b0}};
            remainder_q <= {VW{1'b0}};
            dvd_q       <= {DW{1'b0}};
            dvs_q       <= {VW{1'b0}};
            rem_q       <= {(VW+1){1'b0}};
            qacc_q      <= {DW{1'b0}};
            cnt_q       <= {CW{1'b0}};
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            dz_q        <= dz_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dvd_q       <= dvd_d;
            dvs_q       <= dvs_d;
            rem_q       <= rem_d;
            qacc_q      <= qacc_d;
            cnt_q       <= cnt_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign dz        = dz_q;
    assign quotient  = quotient_q;
    assign remainder = remainder_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: vector table, corner sequences and
// randomized operands against an arithmetic reference model.
module tb_seq_divider;

    localparam int DW = 10;
    localparam int VW = 8;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [DW-1:0] dividend;
    logic [VW-1:0] divisor;
    logic          busy;
    logic          done;
    logic          dz;
    logic [DW-1:0] quotient;
    logic [VW-1:0] remainder;

    int n_checks = 0;
    int n_fail   = 0;
    int last_q   = 0;
    int last_r   = 0;
    int last_dz  = 0;

    typedef struct {
        logic [DW-1:0] a;
        logic [VW-1:0] b;
        int            q;
        int            r;
        int            z;
        string         nm;
    } vec_t;

    vec_t vecs[6];

    seq_divider #(.DW(DW), .VW(VW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .dz        (dz),
        .quotient  (quotient),
        .remainder (remainder)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Reference: plain unsigned division, saturated quotient on zero divisor.
    task automatic ref_div(input int a, input int b, output int q, output int r, output int z);
        if (b == 0) begin
            q = (1 << DW) - 1;
            r = a % (1 << VW);
            z = 1;
        end else begin
            q = a / b;
            r = a % b;
            z = 0;
        end
    endtask

    // Issue one request, wait for done, check timing, results and stability.
    task automatic run_div(input logic [DW-1:0] a, input logic [VW-1:0] b,
                           input int exp_q, input int exp_r, input int exp_z,
                           input string nm);
        int edge_n;
        int busy_n;
        int unstable;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        edge_n   = 0;
        busy_n   = 0;
        unstable = 0;
        while (!done && edge_n < 40) begin
            if (busy) busy_n++;
            if (quotient != last_q || remainder != last_r || dz != last_dz) unstable = 1;
            @(posedge clk); #1;
            edge_n++;
        end
        chk({nm, " done_edge"}, edge_n, (exp_z != 0) ? 0 : DW);
        chk({nm, " busy_cycles"}, busy_n, (exp_z != 0) ? 0 : DW);
        chk({nm, " busy_at_done"}, int'(busy), 0);
        chk({nm, " quotient"}, int'(quotient), exp_q);
        chk({nm, " remainder"}, int'(remainder), exp_r);
        chk({nm, " dz"}, int'(dz), exp_z);
        chk({nm, " stable_during_calc"}, unstable, 0);
        last_q  = exp_q;
        last_r  = exp_r;
        last_dz = exp_z;
        @(posedge clk); #1;
        chk({nm, " done_one_cycle"}, int'(done), 0);
    endtask

    initial begin
        int edge_n;
        int done_n;
        int cap_q;
        int cap_r;
        int cap_edge;
        int q;
        int r;
        int z;
        logic [DW-1:0] ra;
        logic [VW-1:0] rb;

        vecs[0] = '{a: 10'd765,  b: 8'd3,   q: 255,  r: 0,    z: 0, nm: "full_scale"};
        vecs[1] = '{a: 10'd100,  b: 8'd7,   q: 14,   r: 2,    z: 0, nm: "100_7"};
        vecs[2] = '{a: 10'd5,    b: 8'd9,   q: 0,    r: 5,    z: 0, nm: "5_9"};
        vecs[3] = '{a: 10'd1023, b: 8'd255, q: 4,    r: 3,    z: 0, nm: "1023_255"};
        vecs[4] = '{a: 10'd600,  b: 8'd0,   q: 1023, r: 88,   z: 1, nm: "div_zero"};
        vecs[5] = '{a: 10'd9,    b: 8'd3,   q: 3,    r: 0,    z: 0, nm: "9_3_after_dz"};

        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = 10'd0;
        divisor  = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        chk("reset dz", int'(dz), 0);
        chk("reset quotient", int'(quotient), 0);
        chk("reset remainder", int'(remainder), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) begin
            run_div(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].z, vecs[i].nm);
        end

        // start pulsed with new operands in the 4th CALC cycle must be ignored
        dividend = 10'd765;
        divisor  = 8'd3;
        start    = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        done_n = 0;
        cap_q  = -1;
        cap_r  = -1;
        cap_edge = -1;
        for (int i = 1; i <= 15; i++) begin
            if (i == 4) begin
                start    = 1'b1;
                dividend = 10'd10;
                divisor  = 8'd2;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            if (done) begin
                done_n++;
                if (done_n == 1) begin
                    cap_q    = int'(quotient);
                    cap_r    = int'(remainder);
                    cap_edge = i;
                end
            end
        end
        chk("busy_start done_pulses", done_n, 1);
        chk("busy_start done_edge", cap_edge, DW);
        chk("busy_start quotient", cap_q, 255);
        chk("busy_start remainder", cap_r, 0);
        last_q = 255; last_r = 0; last_dz = 0;

        // start held high across done: second division accepted in the done cycle
        dividend = 10'd765;
        divisor  = 8'd3;
        start    = 1'b1;
        @(posedge clk); #1;
        edge_n = 0;
        while (!done && edge_n < 40) begin
            @(posedge clk); #1;
            edge_n++;
        end
        chk("b2b first done_edge", edge_n, DW);
        chk("b2b first quotient", int'(quotient), 255);
        dividend = 10'd200;
        divisor  = 8'd6;
        @(posedge clk); #1;
        start  = 1'b0;
        edge_n = 1;
        while (!done && edge_n < 40) begin
            @(posedge clk); #1;
            edge_n++;
        end
        chk("b2b second spacing", edge_n, DW + 1);
        chk("b2b second quotient", int'(quotient), 33);
        chk("b2b second remainder", int'(remainder), 2);
        last_q = 33; last_r = 2; last_dz = 0;
        @(posedge clk); #1;

        // asynchronous reset in the 5th CALC cycle aborts without a done pulse
        dividend = 10'd765;
        divisor  = 8'd3;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        chk("mid_rst busy", int'(busy), 0);
        chk("mid_rst done", int'(done), 0);
        chk("mid_rst dz", int'(dz), 0);
        chk("mid_rst quotient", int'(quotient), 0);
        chk("mid_rst remainder", int'(remainder), 0);
        @(posedge clk); #1;
        rst_n  = 1'b1;
        done_n = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (done || busy) done_n++;
        end
        chk("mid_rst no_done_after", done_n, 0);
        last_q = 0; last_r = 0; last_dz = 0;
        run_div(10'd50, 8'd5, 10, 0, 0, "after_rst");

        for (int i = 0; i < 30; i++) begin
            ra = DW'($urandom_range(0, 1023));
            if ($urandom_range(0, 7) == 0) rb = 8'd0;
            else rb = VW'($urandom_range(1, 255));
            ref_div(int'(ra), int'(rb), q, r, z);
            run_div(ra, rb, q, r, z, $sformatf("rand%0d_%0d_%0d", i, ra, rb));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
